// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake, an optional 2-entry skid buffer,
// synchronous flush, bubble zeroing and an occupancy output. The payload passes through bit-exact.
module pipe_stage_skid #(
    parameter int DATA_W      = 175,
    parameter bit SKID        = 1'b1,
    parameter bit ZERO_BUBBLE = 1'b1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_ready_q, in_ready_d;
    logic              push, pop;
    logic [DATA_W-1:0] bubble_data;

    assign out_valid   = (state_q != ST_EMPTY);
    assign occupancy   = state_q;
    assign bubble_data = ZERO_BUBBLE ? '0 : main_q;

    // SKID=0 trades a registered in_ready for a combinational path from out_ready.
    // RESET gates in_ready so nothing is accepted while reset is held.
    assign in_ready = SKID ? (in_ready_q & ~RESET) : ((~out_valid | out_ready) & ~RESET);
    assign push     = in_valid & in_ready & ~flush;
    assign pop      = out_valid & out_ready;
    assign out_data = (ZERO_BUBBLE && !out_valid) ? '0 : main_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no latch is inferred.
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;

        if (SKID) begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d = ST_ONE;
                        main_d  = in_data;
                    end
                end
                ST_ONE: begin
                    if (push && pop) begin
                        main_d = in_data;
                    end else if (push) begin
                        state_d = ST_FULL;
                        skid_d  = in_data;
                    end else if (pop) begin
                        state_d = ST_EMPTY;
                        main_d  = bubble_data;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end else begin
            if (push) begin
                state_d = ST_ONE;
                main_d  = in_data;
            end else if (pop) begin
                state_d = ST_EMPTY;
                main_d  = bubble_data;
            end
        end

        // Flush overrides any push or pop evaluated above.
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = bubble_data;
            skid_d  = ZERO_BUBBLE ? '0 : skid_q;
        end

        in_ready_d = (state_d != ST_FULL);
    end

    // NOTE: sequential state uses non-blocking assignments only; the data registers are
    // reset too, because out_data must read zero immediately on RESET.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench for pipe_stage_skid: a scoreboard for the default skid configuration
// plus directed checks of the SKID=0 and ZERO_BUBBLE=0 variants.
module tb_pipe_stage_skid;

    localparam int W = 16;

    logic         CLK;
    logic         RESET;
    int           checks;
    int           errors;
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_head;

    // Instance A: SKID=1, ZERO_BUBBLE=1
    logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [W-1:0] a_in_data, a_out_data;
    logic [1:0]   a_occ;
    // Instance B: SKID=0, ZERO_BUBBLE=1
    logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [W-1:0] b_in_data, b_out_data;
    logic [1:0]   b_occ;
    // Instance C: SKID=1, ZERO_BUBBLE=0
    logic         c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [W-1:0] c_in_data, c_out_data;
    logic [1:0]   c_occ;

    pipe_stage_skid #(.DATA_W(W), .SKID(1'b1), .ZERO_BUBBLE(1'b1)) dut_a (
        .CLK(CLK), .RESET(RESET), .flush(a_flush),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .occupancy(a_occ)
    );

    pipe_stage_skid #(.DATA_W(W), .SKID(1'b0), .ZERO_BUBBLE(1'b1)) dut_b (
        .CLK(CLK), .RESET(RESET), .flush(b_flush),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .occupancy(b_occ)
    );

    pipe_stage_skid #(.DATA_W(W), .SKID(1'b1), .ZERO_BUBBLE(1'b0)) dut_c (
        .CLK(CLK), .RESET(RESET), .flush(c_flush),
        .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .occupancy(c_occ)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Scoreboard monitor for A: at the falling edge the handshake that will complete on the
    // next rising edge is stable, so every pop is compared against the oldest expected payload.
    always @(negedge CLK) begin
        if (!RESET && a_out_valid && a_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_pop: got %h with no payload expected (t=%0t)", a_out_data, $time);
            end else begin
                exp_head = exp_q.pop_front();
                if (a_out_data !== exp_head) begin
                    errors++;
                    $display("FAIL sb_pop: got %h, expected %h (t=%0t)", a_out_data, exp_head, $time);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        RESET  = 1'b1;
        {a_flush, a_in_valid, a_out_ready} = '0; a_in_data = '0;
        {b_flush, b_in_valid, b_out_ready} = '0; b_in_data = '0;
        {c_flush, c_in_valid, c_out_ready} = '0; c_in_data = '0;

        // Reset state
        #2;
        check("rst_out_valid", W'(a_out_valid), W'(1'b0));
        check("rst_out_data",  a_out_data, '0);
        check("rst_occ",       W'(a_occ), W'(2'd0));
        check("rst_in_ready",  W'(a_in_ready), W'(1'b0));
        check("rst_b_in_ready", W'(b_in_ready), W'(1'b0));
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        check("rel_in_ready",   W'(a_in_ready), W'(1'b1));
        check("rel_b_in_ready", W'(b_in_ready), W'(1'b1));
        tick();

        // Stream 1,2,3 with out_ready=1: one per cycle, occupancy stays at 1
        a_out_ready = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            a_in_valid = 1'b1;
            a_in_data  = W'(i);
            exp_q.push_back(W'(i));
            tick();
            check("stream_data",  a_out_data, W'(i));
            check("stream_occ",   W'(a_occ), W'(2'd1));
            check("stream_valid", W'(a_out_valid), W'(1'b1));
        end
        a_in_valid = 1'b0;
        tick();
        check("stream_drain_occ",  W'(a_occ), W'(2'd0));
        check("stream_drain_data", a_out_data, '0);

        // Backpressure: A5 then 5A while out_ready=0 fills both slots
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h00A5;
        exp_q.push_back(16'h00A5);
        tick();
        a_in_data = 16'h005A;
        exp_q.push_back(16'h005A);
        tick();
        a_in_valid = 1'b0;
        check("bp_occ",      W'(a_occ), W'(2'd2));
        check("bp_in_ready", W'(a_in_ready), W'(1'b0));
        check("bp_data",     a_out_data, 16'h00A5);
        tick();
        check("bp_hold_data",  a_out_data, 16'h00A5);
        check("bp_hold_valid", W'(a_out_valid), W'(1'b1));
        a_out_ready = 1'b1;
        tick();
        check("bp_pop1_data",     a_out_data, 16'h005A);
        check("bp_pop1_in_ready", W'(a_in_ready), W'(1'b1));
        check("bp_pop1_occ",      W'(a_occ), W'(2'd1));
        tick();
        check("bp_empty_occ", W'(a_occ), W'(2'd0));

        // Flush with both slots held and a same-cycle 0xFF offer
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h0011;
        exp_q.push_back(16'h0011);
        tick();
        a_in_data = 16'h0022;
        exp_q.push_back(16'h0022);
        tick();
        check("fl_pre_occ", W'(a_occ), W'(2'd2));
        a_flush   = 1'b1;
        a_in_data = 16'h00FF;
        tick();
        a_flush    = 1'b0;
        a_in_valid = 1'b0;
        exp_q.delete();
        check("fl_valid", W'(a_out_valid), W'(1'b0));
        check("fl_data",  a_out_data, '0);
        check("fl_occ",   W'(a_occ), W'(2'd0));
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("fl_quiet_valid", W'(a_out_valid), W'(1'b0));
        end

        // SKID=0: in_ready follows out_ready combinationally
        b_out_ready = 1'b0;
        b_in_valid  = 1'b1;
        b_in_data   = 16'h0031;
        tick();
        b_in_valid = 1'b0;
        #1;
        check("b_valid",         W'(b_out_valid), W'(1'b1));
        check("b_in_ready_held", W'(b_in_ready), W'(1'b0));
        b_out_ready = 1'b1;
        #1;
        check("b_in_ready_comb", W'(b_in_ready), W'(1'b1));
        b_in_valid = 1'b1;
        b_in_data  = 16'h0032;
        tick();
        b_in_valid = 1'b0;
        check("b_replace_data", b_out_data, 16'h0032);
        check("b_replace_occ",  W'(b_occ), W'(2'd1));
        tick();
        check("b_drain_valid", W'(b_out_valid), W'(1'b0));
        check("b_drain_data",  b_out_data, '0);

        // ZERO_BUBBLE=0: stale payload stays visible after draining
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_data   = 16'h0007;
        tick();
        c_in_valid = 1'b0;
        check("c_data", c_out_data, 16'h0007);
        tick();
        check("c_bubble_valid", W'(c_out_valid), W'(1'b0));
        check("c_bubble_data",  c_out_data, 16'h0007);

        // Asynchronous reset with both slots held
        a_out_ready = 1'b0;
        a_in_valid  = 1'b1;
        a_in_data   = 16'h0033;
        exp_q.push_back(16'h0033);
        tick();
        a_in_data = 16'h0044;
        exp_q.push_back(16'h0044);
        tick();
        a_in_valid = 1'b0;
        check("ar_pre_occ", W'(a_occ), W'(2'd2));
        #3;
        RESET = 1'b1;
        #1;
        exp_q.delete();
        check("ar_valid",    W'(a_out_valid), W'(1'b0));
        check("ar_data",     a_out_data, '0);
        check("ar_occ",      W'(a_occ), W'(2'd0));
        check("ar_in_ready", W'(a_in_ready), W'(1'b0));
        #3;
        RESET = 1'b0;
        #1;
        check("ar_rel_in_ready", W'(a_in_ready), W'(1'b1));
        tick();
        check("ar_post_occ", W'(a_occ), W'(2'd0));

        check("sb_leftover", W'(exp_q.size()), '0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
